// File: rtl/soc_pkg.sv
// soc_pkg: shared definitions for the data-memory path.
//   DMEM_* localparams : default data-memory geometry.
//   REQ_CPU / REQ_DBG  : requester indices on the dmem arbiter.
//   dmem_req_t         : one request payload {we, strb, addr, wdata}.
package soc_pkg;

  localparam int DMEM_ADDR_WIDTH = 10;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_STRB_WIDTH = DMEM_DATA_WIDTH / 8;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  typedef struct packed {
    logic                       we;
    logic [DMEM_STRB_WIDTH-1:0] strb;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side bus of the dmem arbiter.
//   master : requesters (drive req_valid/req_we/req_strb/req_addr/req_wdata,
//            receive req_ready/rsp_valid/rsp_rdata).
//   slave  : the arbiter.
// dmem_port_if: single synchronous-read memory port.
//   master : the arbiter (drives mem_en/mem_we/mem_wstrb/mem_addr/mem_wdata).
//   slave  : the memory (drives mem_rdata, valid one cycle after issue).
interface dmem_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0]                 req_we;
  logic [NREQ-1:0][STRB_WIDTH-1:0] req_strb;
  logic [NREQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NREQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_rdata;

  modport master (
    output req_valid, req_we, req_strb, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_strb, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

interface dmem_port_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  mem_en;
  logic                  mem_we;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter.sv
// rr_arbiter: generic NREQ-way round-robin picker.
//   clk, rst : clock, synchronous active-high reset.
//   req_i    : request vector.
//   adv_i    : a grant was consumed this cycle; move last_grant to it.
//   gnt_o    : one-hot grant (zero when nothing requests).
// Search starts one past the last consumed grant and wraps modulo NREQ.
// Reset leaves last_grant at NREQ-1 so index 0 wins first.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] pick;
  logic            found;
  int              idx;

  always_comb begin
    gnt_o = '0;
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_q) + off) % NREQ;
      if (!found && req_i[IDXW'(idx)]) begin
        found             = 1'b1;
        pick              = IDXW'(idx);
        gnt_o[IDXW'(idx)] = 1'b1;
      end
    end
  end

  // Only a consumed grant moves the pointer; an offered but unused grant
  // must not rotate priority away from its owner.
  assign last_d = (adv_i && found) ? pick : last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDXW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous-read data-memory port between NREQ
// requesters (index 0 = CPU, 1 = debug/DMA) with round-robin arbitration.
//   clk      : clock, rising edge.
//   rst      : synchronous active-high reset.
//   req_bus  : requester handshake, payload, response strobe and data.
//   mem_bus  : memory port; mem_rdata is valid the cycle after issue.
// A transfer drives mem_* combinationally in the same cycle; the owner and
// write flag are registered so the response is steered back one cycle later.
module dmem_arbiter
  import soc_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
  input logic             clk,
  input logic             rst,
  dmem_arbiter_if.slave   req_bus,
  dmem_port_if.master     mem_bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_act;
  logic [NREQ-1:0]       gnt;
  logic                  xfer;
  dmem_req_t             sel;
  logic [IDXW-1:0]       sel_idx;

  logic                  rsp_pend_q, rsp_pend_d;
  logic [IDXW-1:0]       owner_q, owner_d;
  logic                  we_q, we_d;

  logic [NREQ-1:0]       rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // Masking requests during reset keeps req_ready and mem_en low and stops
  // the arbiter pointer from moving.
  assign req_act = rst ? '0 : req_bus.req_valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_act),
    .adv_i (xfer),
    .gnt_o (gnt)
  );

  assign xfer              = |gnt;
  assign req_bus.req_ready = gnt;

  // Payload mux; all-zero when nothing is granted so mem_* idle at 0.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.we    = req_bus.req_we[i];
        sel.strb  = req_bus.req_strb[i];
        sel.addr  = req_bus.req_addr[i];
        sel.wdata = req_bus.req_wdata[i];
        sel_idx   = IDXW'(i);
      end
    end
  end

  assign mem_bus.mem_en    = xfer;
  assign mem_bus.mem_we    = sel.we;
  assign mem_bus.mem_wstrb = sel.we ? sel.strb : '0;
  assign mem_bus.mem_addr  = sel.addr;
  assign mem_bus.mem_wdata = sel.wdata;

  // Response tag pipeline, one register deep, never stalls.
  assign rsp_pend_d = xfer;
  assign owner_d    = xfer ? sel_idx : owner_q;
  assign we_d       = xfer ? sel.we  : we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_q <= 1'b0;
      owner_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
    end
  end

  // The rst gate drops a response whose transfer happened the cycle before
  // reset: the tag register still holds it until the reset edge.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rsp_pend_q && !rst) begin
      rsp_valid[owner_q] = 1'b1;
      if (!we_q) begin
        rsp_rdata = mem_bus.mem_rdata;
      end
    end
  end

  assign req_bus.rsp_valid = rsp_valid;
  assign req_bus.rsp_rdata = rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a
// spec-level model checked every cycle, plus hand-computed directed checks.
module tb_dmem_arbiter;
  import soc_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rb ();
  dmem_port_if    #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW))              mb ();

  dmem_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_bus (rb),
    .mem_bus (mb)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 4)  return 32'hDEADBEEF;
    if (i == 16) return 32'hAABBCCDD;
    return 32'hC0DE0000 + DW'(i);
  endfunction

  // ---------------- behavioural memory (port A) ----------------
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rdata_q;
  bit            mem_loaded = 1'b0;
  assign mb.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mb.mem_en) begin
      if (mb.mem_we) begin
        for (int b = 0; b < SW; b++)
          if (mb.mem_wstrb[b]) mem[mb.mem_addr][b*8 +: 8] <= mb.mem_wdata[b*8 +: 8];
      end else begin
        rdata_q <= mem[mb.mem_addr];
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [DW-1:0] ref_mem [1024];
  bit            ref_loaded = 1'b0;
  int            m_last = NREQ - 1;
  bit            m_pend = 1'b0;
  int            m_owner = 0;
  bit            m_we = 1'b0;
  logic [DW-1:0] m_data = '0;

  always @(negedge clk) begin : cmp
    int            g;
    int            ii;
    logic [NREQ-1:0] e_ready, e_rsp;
    logic          e_we;
    logic [SW-1:0] e_strb;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    if (!ref_loaded) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    g = -1;
    if (!rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        ii = (m_last + k) % NREQ;
        if (g < 0 && rb.req_valid[ii]) g = ii;
      end
    end
    e_ready = '0; e_we = 1'b0; e_strb = '0; e_addr = '0; e_wdata = '0;
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      e_we       = rb.req_we[g];
      e_strb     = e_we ? rb.req_strb[g] : '0;
      e_addr     = rb.req_addr[g];
      e_wdata    = rb.req_wdata[g];
    end
    e_rsp = '0; e_rdata = '0;
    if (m_pend && !rst) begin
      e_rsp[m_owner] = 1'b1;
      if (!m_we) e_rdata = m_data;
    end
    chk("req_ready", rb.req_ready, e_ready);
    chk("mem_en",    mb.mem_en,    (g >= 0));
    chk("mem_we",    mb.mem_we,    e_we);
    chk("mem_wstrb", mb.mem_wstrb, e_strb);
    chk("mem_addr",  mb.mem_addr,  e_addr);
    chk("mem_wdata", mb.mem_wdata, e_wdata);
    chk("rsp_valid", rb.rsp_valid, e_rsp);
    chk("rsp_rdata", rb.rsp_rdata, e_rdata);
    if (rst) begin
      m_last = NREQ - 1;
      m_pend = 1'b0;
    end else begin
      m_pend = (g >= 0);
      if (g >= 0) begin
        m_owner = g;
        m_we    = e_we;
        m_data  = ref_mem[e_addr];
        if (e_we)
          for (int b = 0; b < SW; b++)
            if (e_strb[b]) ref_mem[e_addr][b*8 +: 8] = e_wdata[b*8 +: 8];
        m_last = g;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    rb.req_valid = '0;
    rb.req_we    = '0;
    rb.req_strb  = '0;
    rb.req_addr  = '0;
    rb.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit we, input logic [SW-1:0] strb,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    rb.req_valid[i] = 1'b1;
    rb.req_we[i]    = we;
    rb.req_strb[i]  = strb;
    rb.req_addr[i]  = addr;
    rb.req_wdata[i] = wd;
  endtask

  initial begin
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] prev_g;
    int              nc, nd;
    idle();
    rst = 1'b1;
    tick();
    tick();
    // Requests held during reset must not be granted.
    set_req(REQ_CPU, 1'b0, 4'h0, 10'h001, 32'h0);
    set_req(REQ_DBG, 1'b0, 4'h0, 10'h002, 32'h0);
    mid();
    chk("rst_ready", rb.req_ready, 2'b00);
    chk("rst_mem_en", mb.mem_en, 1'b0);
    tick();
    idle();
    rst = 1'b0;
    mid();
    chk("idle_rsp", rb.rsp_valid, 2'b00);
    tick();

    // CPU read of 0x004 after reset.
    set_req(REQ_CPU, 1'b0, 4'hF, 10'h004, 32'h0);
    mid();
    chk("t1_ready", rb.req_ready, 2'b01);
    chk("t1_addr", mb.mem_addr, 10'h004);
    tick();
    idle();
    mid();
    chk("t1_rsp_valid", rb.rsp_valid, 2'b01);
    chk("t1_rsp_rdata", rb.rsp_rdata, 32'hDEADBEEF);
    chk("idle_mem_en", mb.mem_en, 1'b0);
    chk("idle_wstrb", mb.mem_wstrb, 4'h0);
    chk("idle_ready", rb.req_ready, 2'b00);
    tick();
    mid();
    chk("idle_rsp_after", rb.rsp_valid, 2'b00);

    // Transfer at T, reset at T+1: response dropped.
    tick();
    set_req(REQ_CPU, 1'b0, 4'h0, 10'h008, 32'h0);
    mid();
    chk("t5_ready", rb.req_ready, 2'b01);
    tick();
    rst = 1'b1;
    set_req(REQ_CPU, 1'b0, 4'h0, 10'h030, 32'h0);
    set_req(REQ_DBG, 1'b0, 4'h0, 10'h020, 32'h0);
    mid();
    chk("t5_rsp_dropped", rb.rsp_valid, 2'b00);
    chk("t5_rst_ready", rb.req_ready, 2'b00);
    tick();
    rst = 1'b0;

    // Both requesters active: 0,1,0,1,0,1 starting from requester 0.
    nc = 0; nd = 0;
    prev_g = '0;
    for (int n = 0; n < 6; n++) begin
      mid();
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_seq", rb.req_ready, exp_g);
      if (n > 0) chk("rr_rsp_follow", rb.rsp_valid, prev_g);
      prev_g = exp_g;
      tick();
      if (exp_g[0]) begin nc++; rb.req_addr[REQ_CPU] = 10'h030 + AW'(nc); end
      else          begin nd++; rb.req_addr[REQ_DBG] = 10'h020 + AW'(nd); end
    end
    idle();
    mid();
    chk("rr_last_rsp", rb.rsp_valid, 2'b10);
    chk("rr_last_rdata", rb.rsp_rdata, 32'hC0DE0022);

    // Debug partial write, then CPU read of the same word next cycle.
    tick();
    set_req(REQ_DBG, 1'b1, 4'b0011, 10'h010, 32'h12345678);
    mid();
    chk("t3_wr_ready", rb.req_ready, 2'b10);
    chk("t3_wstrb", mb.mem_wstrb, 4'b0011);
    tick();
    idle();
    set_req(REQ_CPU, 1'b0, 4'hF, 10'h010, 32'h0);
    mid();
    chk("t3_wr_rsp", rb.rsp_valid, 2'b10);
    chk("t3_wr_rdata", rb.rsp_rdata, 32'h0);
    chk("t3_rd_ready", rb.req_ready, 2'b01);
    chk("t3_rd_wstrb", mb.mem_wstrb, 4'b0000);
    tick();
    idle();
    mid();
    chk("t3_rd_rsp", rb.rsp_valid, 2'b01);
    chk("t3_rd_rdata", rb.rsp_rdata, 32'hAABB5678);
    chk("t3_mem_word", mem[16], 32'hAABB5678);

    // CPU alone, 8 back-to-back reads of 0..7.
    tick();
    set_req(REQ_CPU, 1'b0, 4'h0, 10'h000, 32'h0);
    for (int k = 0; k < 8; k++) begin
      rb.req_addr[REQ_CPU] = AW'(k);
      mid();
      chk("burst_ready", rb.req_ready, 2'b01);
      if (k > 0) begin
        chk("burst_rsp_valid", rb.rsp_valid, 2'b01);
        chk("burst_rsp_rdata", rb.rsp_rdata,
            (k - 1 == 4) ? 32'hDEADBEEF : 32'hC0DE0000 + DW'(k - 1));
      end
      tick();
    end
    idle();
    mid();
    chk("burst_last_rsp", rb.rsp_valid, 2'b01);
    chk("burst_last_rdata", rb.rsp_rdata, 32'hC0DE0007);
    tick();
    mid();
    chk("final_idle_rsp", rb.rsp_valid, 2'b00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single core-side port of the data memory between `NREQ` requesters: the CPU LSU interconnect (index 0) and the debug/DMA master (index 1). It accepts at most one request per cycle, drives the synchronous-read memory port, and routes the one-cycle-latency response back to the requester that issued it. It sits between `lsu_interconnect`/debug master and `dmem` port A, and frees port B for other use.

## Interface

Parameters:
- `NREQ`, 2, number of requesters; index 0 is the CPU.
- `ADDR_WIDTH`, 10, word-address width of the data memory.
- `DATA_WIDTH`, 32, data width; strobe width is `DATA_WIDTH/8`.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NREQ`  request pending per requester.
- `req_ready`  out  `NREQ`  request accepted this cycle (one-hot or zero).
- `req_we`  in  `NREQ`  1 = write, 0 = read.
- `req_strb`  in  `NREQ` x `DATA_WIDTH/8`  byte enables for writes.
- `req_addr`  in  `NREQ` x `ADDR_WIDTH`  word address.
- `req_wdata`  in  `NREQ` x `DATA_WIDTH`  write data.
- `rsp_valid`  out  `NREQ`  response strobe, one cycle, per requester.
- `rsp_rdata`  out  `DATA_WIDTH`  response data, shared bus.
- `mem_en`, `mem_we`  out  1  memory port enable / write enable.
- `mem_wstrb`  out  `DATA_WIDTH/8`  memory byte enables.
- `mem_addr`  out  `ADDR_WIDTH`  memory word address.
- `mem_wdata`  out  `DATA_WIDTH`  memory write data.
- `mem_rdata`  in  `DATA_WIDTH`  memory read data, valid one cycle after issue.

## Operation

- Handshake: requester holds `req_valid` and payload stable until `req_valid & req_ready`. Transfer happens in that cycle.
- Grant: round-robin over requesters with `req_valid` set. The search starts at `last_grant+1` and wraps modulo `NREQ`. `last_grant` updates only on a transfer.
- At most one `req_ready` bit is set per cycle. `req_ready[i]` is never set without `req_valid[i]`.
- On a transfer, `mem_en=1` and the `mem_*` signals carry the granted payload, combinationally in the same cycle. `mem_wstrb` is forced to 0 for reads. With no transfer, all `mem_*` outputs are 0.
- Response: in the cycle after every transfer (read or write), `rsp_valid[owner]=1` for exactly one cycle. The owner tag and the `we` flag are registered at the transfer.
- `rsp_rdata = mem_rdata` for reads, and 0 for writes and when `rsp_valid` is all zero.
- There is no response backpressure. Requesters must sink `rsp_valid`.
- Back-to-back transfers are allowed every cycle. The response pipeline is one register deep and never stalls.
- Reset values: `last_grant = NREQ-1`, so requester 0 wins first after reset. `rsp_valid = 0`, owner tag = 0, we flag = 0.
- During `rst`: `req_ready = 0` and `mem_en = 0`.
- Boundary conditions:
  - Single active requester: granted every cycle.
  - All requesters active: grants strictly alternate 0,1,0,1…
  - Reset asserted the cycle after a transfer: the pending response is dropped and `rsp_valid` stays 0.
  - Write at T, read of the same address at T+1: the read observes the new data, since the write commits at T's edge.
  - `last_grant` wraps from `NREQ-1` to 0.

## Timing

- Request-to-grant: 0 cycles when uncontested. Worst-case wait is `NREQ-1` transfers.
- Grant-to-response: exactly 1 cycle.
- Combinational path `req_valid → req_ready → mem_*`. There is no path from `mem_rdata` to `req_ready`.
- Throughput: 1 transfer per cycle aggregate.

## Structure

- Shared package `soc_pkg` holds:
  - `dmem_req_t` struct {we, strb, addr, wdata}, sized by `ADDR_WIDTH`/`DATA_WIDTH`;
  - `localparam` requester indices `REQ_CPU=0`, `REQ_DBG=1`.
- Sub-module `rr_arbiter`: generic `NREQ` round-robin picker holding the `last_grant` register. Inputs: request vector and advance enable. Output: one-hot grant.
- `dmem_arbiter` contains the payload mux, the response owner/we registers and the response demux.

## Test plan

- Reset release, both idle, then CPU read addr 0x004 (mem holds 0xDEADBEEF) → `req_ready=01` at T; `rsp_valid=01`, `rsp_rdata=0xDEADBEEF` at T+1.
- Both requesters hold `req_valid` for 6 cycles → grant sequence 0,1,0,1,0,1; each `rsp_valid` bit follows its grant by 1 cycle.
- Debug write 0x12345678, strb 0b0011, addr 0x010, then CPU read 0x010 next cycle → memory word has low half 0x5678; CPU `rsp_rdata` reflects it; debug `rsp_rdata=0`.
- CPU alone, 8 back-to-back reads of addresses 0..7 → `req_ready[0]` high 8 consecutive cycles; 8 consecutive responses in order.
- Transfer at T, `rst` high at T+1 → `rsp_valid=0` at T+1; after release the first grant goes to requester 0.
- `req_valid` deasserted on both → `mem_en=0`, `mem_wstrb=0`, `req_ready=0`, `rsp_valid=0` next cycle.
